// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector bench:
// FSM state encoding, default width and the length clamp.
package seq_pkg;

  localparam int SEQ_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  // Requests longer than the shift register are trimmed to its full width.
  function automatic int unsigned seq_clamp_len(input int unsigned len,
                                                input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_expect_model.sv
// Cycle-accurate model of the repeated-bit detector output z, fed from the
// transmitter's registered w so that it sees idle zeros exactly as the detector does.
module seq_expect_model #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             w,
  input  logic             w_valid,
  input  logic             clear,
  output logic             exp_z,
  output logic [CNT_W-1:0] hit_cnt
);

  logic             r_prev;
  logic             r_have_prev;
  logic             r_exp_z;
  logic [CNT_W-1:0] r_hit_cnt;
  logic             w_hit;

  assign w_hit = r_have_prev && (w == r_prev);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev      <= 1'b0;
      r_have_prev <= 1'b0;
      r_exp_z     <= 1'b0;
      r_hit_cnt   <= '0;
    end else begin
      r_exp_z     <= w_hit;
      r_prev      <= w;
      r_have_prev <= 1'b1;
      // A new pattern's clear outranks a hit on the previous pattern's last bit.
      if (clear)
        r_hit_cnt <= '0;
      else if (w_hit && w_valid && (r_hit_cnt != {CNT_W{1'b1}}))
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
    end
  end

  assign exp_z   = r_exp_z;
  assign hit_cnt = r_hit_cnt;

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a parallel word out MSB-first on w.
// Define SEQ_EXPECT_EN to add the exp_z / hit_cnt detector model outputs.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH_DEFAULT,
  parameter int LEN_W = $clog2(WIDTH + 1),
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             w,
  output logic             w_valid,
`ifdef SEQ_EXPECT_EN
  output logic             exp_z,
  output logic [CNT_W-1:0] hit_cnt,
`endif
  output seq_state_e       dbg_state
);

  seq_state_e       r_state;
  logic [WIDTH-1:0] r_sr;
  logic [LEN_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_w;
  logic             r_w_valid;
  logic             w_accept;
  logic [LEN_W-1:0] w_len_clamped;

  // Handshake: start/pattern/len form a request that is taken on the edge where
  // the FSM is IDLE or DONE, len is non-zero and abort is low; anything else drops it.
  assign w_accept      = start && (len != '0) && !abort &&
                         ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_len_clamped = LEN_W'(seq_clamp_len(32'(len), WIDTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_w       <= 1'b0;
      r_w_valid <= 1'b0;
    end else begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_w       <= 1'b0;
      r_w_valid <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= (r_state == ST_DONE);
          if (w_accept) begin
            r_sr    <= pattern;
            r_cnt   <= w_len_clamped;
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            r_sr    <= '0;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_w       <= r_sr[WIDTH-1];
            r_w_valid <= 1'b1;
            r_busy    <= 1'b1;
            r_sr      <= {r_sr[WIDTH-2:0], 1'b0};
            r_cnt     <= r_cnt - LEN_W'(1);
            // Count of 1 means the bit going out now is the last one.
            if (r_cnt == LEN_W'(1))
              r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign w         = r_w;
  assign w_valid   = r_w_valid;
  assign dbg_state = r_state;

`ifdef SEQ_EXPECT_EN
  seq_expect_model #(
    .CNT_W (CNT_W)
  ) u_expect (
    .clk     (clk),
    .reset_n (reset_n),
    .w       (r_w),
    .w_valid (r_w_valid),
    .clear   (w_accept),
    .exp_z   (exp_z),
    .hit_cnt (hit_cnt)
  );
`endif

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives the single-bit `w` stream consumed by the team's repeated-bit sequence detector. It accepts a parallel pattern word plus bit length through a start handshake and shifts it out MSB-first, one bit per clock. It optionally carries a cycle-accurate model of the detector's `z` output, so benches and self-test logic can check the detector without a separate golden model.

## Interface
- `WIDTH`, 8: maximum pattern length in bits; legal range 2–32.
- `LEN_W`, `$clog2(WIDTH+1)`: width of `len`.
- `CNT_W`, `$clog2(WIDTH)`: width of `hit_cnt`.

- `clk`: input, 1 bit. Clock; all state changes on the rising edge.
- `reset_n`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Request to send `pattern`; sampled every cycle.
- `pattern`: input, `WIDTH` bits. Bits to send; bit `WIDTH-1` goes first.
- `len`: input, `LEN_W` bits. Number of bits to send, taken from the MSB end.
- `abort`: input, 1 bit. Synchronous cancel of the transfer in progress.
- `busy`: output, 1 bit. High while bits are being shifted.
- `done`: output, 1 bit. One-cycle pulse after the last bit.
- `w`: output, 1 bit. Serial data to the detector; 0 whenever not sending.
- `w_valid`: output, 1 bit. High in cycles where `w` carries a pattern bit.
- `exp_z`: output, 1 bit. Expected detector `z`; present only with the macro.
- `hit_cnt`: output, `CNT_W` bits. Expected `z` hits during the current or last pattern; present only with the macro.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Reset values: state IDLE; `busy`, `done`, `w`, `w_valid` all 0; shift register and bit counter 0. With the macro, `exp_z`, `hit_cnt` and the model's history flag are also 0.

- IDLE: `start=1` with `len!=0` is accepted.
  - `pattern` is copied into the shift register.
  - The counter is loaded with `min(len, WIDTH)`.
  - Next state is SHIFT.
- IDLE, `len==0`: `start` is ignored and the FSM stays in IDLE.
- SHIFT, each cycle:
  - `w` is the shift-register MSB and `w_valid=1`.
  - The shift register moves left by one, filling with 0.
  - The counter decrements.
  - When the counter reaches 1 (last bit on the line), next state is DONE.
- DONE, one cycle:
  - `done=1`, `w_valid=0`, `w=0`, `busy=0`.
  - An acceptable `start` here is taken exactly as in IDLE and next state is SHIFT; otherwise next state is IDLE.
- `start` while in SHIFT is ignored; no queuing.
- `abort` while in SHIFT:
  - Next state is IDLE and `w`/`w_valid` drop.
  - No `done` pulse; the bits already sent stand.
- `abort` in IDLE or DONE has no effect.
- `abort` together with an acceptable `start` in IDLE or DONE: abort wins and the start is dropped.
- Asynchronous reset mid-transfer forces every output to its reset value immediately.
- All outputs are registered.

## Timing
Take `start` as sampled at edge k.
- Bit i (0-based) is on `w` with `w_valid=1` in the cycle after edge k+1+i, for i from 0 to L-1, where L is the clamped length.
- `busy` is high in those same L cycles.
- `done` is high in the cycle after edge k+1+L.
- Back-to-back patterns: the minimum gap is one non-valid cycle (the DONE cycle).
- Latency from `start` to the first bit is 1 cycle.

## Configuration
- Macro `SEQ_EXPECT_EN`, when defined: compiles in `exp_z` and `hit_cnt`.
  - Every edge: `exp_z <= have_prev && (w == prev)`, then `prev <= w` and `have_prev <= 1`.
  - `w` here is the registered output, including the 0s sent while idle. This reproduces the detector, which sees `w` every cycle and stays unreset between patterns.
  - `exp_z` therefore lines up with detector `z` when both are reset together.
  - `hit_cnt` clears when a `start` is accepted and increments on each edge where the update sets `exp_z` to 1 while `w_valid=1`.
  - `hit_cnt` saturates at its maximum value.
- Macro not defined: neither port exists and the model logic is absent. The behaviour of `w`, `w_valid`, `busy` and `done` is unchanged.

## Structure
- Package `seq_pkg`, shared with the detector's bench:
  - state enum with IDLE, SHIFT and DONE;
  - `SEQ_WIDTH_DEFAULT` constant;
  - a length-clamp function.
- Sub-module `seq_expect_model` holds `prev`, `have_prev`, `exp_z` and `hit_cnt`. It is instantiated only under `SEQ_EXPECT_EN`.

## Test plan
- **Reset:** hold `reset_n=0` for 3 cycles. All outputs must be 0, and `exp_z=0` on the first `w` sample after release.
- **Alternating pattern:** `pattern=8'b1011_0010`, `len=8`. `w` must read 1,0,1,1,0,0,1,0 in 8 consecutive valid cycles, followed by one `done` pulse. `hit_cnt` must end at 2.
- **Short length:** `pattern=8'hFF`, `len=3`. Exactly 3 valid 1s, then `done`. The `exp_z` pulses must match a detector instance cycle-for-cycle.
- **Back-to-back:** hold `start` high through the DONE cycle. The second pattern's first bit must appear on the cycle right after `done`.
- **Abort:** assert `abort` during the 4th bit of an 8-bit pattern. `w_valid` must drop on the next cycle, with no `done` pulse.
- **Boundary inputs:** `len=0` must produce no activity, and `len` greater than `WIDTH` must send exactly `WIDTH` bits. A `start` while `busy` must be ignored, leaving the shifted bits unchanged.
